// File: rtl/mem_arbiter.sv
// Shared asynchronous SRAM sequencer: arbitrates video, CPU and aux DMA requesters and drives
// CE/OE/WE with a programmable strobe width, acking each access with a single-cycle pulse.
module mem_arbiter #(
  parameter int unsigned ADDR_W          = 18,
  parameter int unsigned DATA_W          = 8,
  parameter int unsigned ACCESS_CYCLES   = 2,
  parameter int unsigned VIDEO_MAX_BURST = 4
) (
  input  logic              clkMem,
  input  logic              rst_n,
  input  logic              vid_req,
  input  logic              cpu_req,
  input  logic              aux_req,
  input  logic [ADDR_W-1:0] vid_addr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic              cpu_we,
  input  logic              aux_we,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [DATA_W-1:0] aux_wdata,
  output logic              vid_ack,
  output logic              cpu_ack,
  output logic              aux_ack,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wdata_oe,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ce_n,
  output logic              mem_oe_n,
  output logic              mem_we_n,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StRecover} state_e;
  typedef enum logic [1:0] {SrcVid, SrcCpu, SrcAux} src_e;

  state_e     state_q;
  src_e       src_q;
  logic       we_q;
  logic [3:0] cnt_q;
  logic [3:0] burst_q;
  logic       rr_aux_q;

  logic              grant_vid, grant_cpu, grant_aux, grant_any;
  src_e              sel_src;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we;

  // Video wins unless it has used up its burst allowance while someone else is waiting.
  always_comb begin
    grant_vid = 1'b0;
    grant_cpu = 1'b0;
    grant_aux = 1'b0;
    if (vid_req && ((burst_q < 4'(VIDEO_MAX_BURST)) || !(cpu_req || aux_req))) begin
      grant_vid = 1'b1;
    end else if (cpu_req && aux_req) begin
      grant_aux = rr_aux_q;
      grant_cpu = !rr_aux_q;
    end else begin
      grant_cpu = cpu_req;
      grant_aux = aux_req;
    end
    grant_any = grant_vid | grant_cpu | grant_aux;
  end

  always_comb begin
    sel_src   = SrcVid;
    sel_addr  = vid_addr;
    sel_we    = 1'b0;
    sel_wdata = mem_wdata;
    if (grant_cpu) begin
      sel_src   = SrcCpu;
      sel_addr  = cpu_addr;
      sel_we    = cpu_we;
      sel_wdata = cpu_wdata;
    end else if (grant_aux) begin
      sel_src   = SrcAux;
      sel_addr  = aux_addr;
      sel_we    = aux_we;
      sel_wdata = aux_wdata;
    end
  end

  always_ff @(posedge clkMem or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      src_q        <= SrcVid;
      we_q         <= 1'b0;
      cnt_q        <= '0;
      burst_q      <= '0;
      rr_aux_q     <= 1'b0;
      vid_ack      <= 1'b0;
      cpu_ack      <= 1'b0;
      aux_ack      <= 1'b0;
      rd_data      <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wdata_oe <= 1'b0;
      mem_ce_n     <= 1'b1;
      mem_oe_n     <= 1'b1;
      mem_we_n     <= 1'b1;
      busy         <= 1'b0;
    end else begin
      vid_ack <= 1'b0;
      cpu_ack <= 1'b0;
      aux_ack <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_any) begin
            state_q      <= StSetup;
            busy         <= 1'b1;
            src_q        <= sel_src;
            we_q         <= sel_we;
            mem_addr     <= sel_addr;
            mem_wdata    <= sel_wdata;
            mem_wdata_oe <= sel_we;
            mem_ce_n     <= 1'b0;
            if (grant_vid) begin
              burst_q <= (burst_q == 4'd15) ? 4'd15 : burst_q + 4'd1;
            end else begin
              burst_q  <= '0;
              rr_aux_q <= grant_cpu;
            end
          end else begin
            burst_q <= '0;
          end
        end
        StSetup: begin
          state_q  <= StStrobe;
          cnt_q    <= 4'(ACCESS_CYCLES - 1);
          mem_oe_n <= we_q;
          mem_we_n <= !we_q;
        end
        StStrobe: begin
          if (cnt_q == 4'd0) begin
            state_q  <= StRecover;
            mem_oe_n <= 1'b1;
            mem_we_n <= 1'b1;
            if (!we_q) begin
              rd_data <= mem_rdata;
            end
            vid_ack <= (src_q == SrcVid);
            cpu_ack <= (src_q == SrcCpu);
            aux_ack <= (src_q == SrcAux);
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StRecover: begin
          state_q      <= StIdle;
          busy         <= 1'b0;
          mem_ce_n     <= 1'b1;
          mem_wdata_oe <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed timeline checks plus randomized traffic
// compared against a transaction-level arbitration/memory model.
module tb_mem_arbiter;

  localparam int AC  = 2;
  localparam int VMB = 4;
  localparam int ACB = 1;

  logic        clkMem = 1'b0;
  logic        rst_n;
  logic        vid_req, cpu_req, aux_req;
  logic [17:0] vid_addr, cpu_addr, aux_addr;
  logic        cpu_we, aux_we;
  logic [7:0]  cpu_wdata, aux_wdata;

  logic        vid_ack, cpu_ack, aux_ack, mem_wdata_oe, mem_ce_n, mem_oe_n, mem_we_n, busy;
  logic [7:0]  rd_data, mem_wdata, mem_rdata;
  logic [17:0] mem_addr;

  logic        b_vid_ack, b_cpu_ack, b_aux_ack, b_wdata_oe, b_ce_n, b_oe_n, b_we_n, b_busy;
  logic [7:0]  b_rd_data, b_wdata, b_rdata;
  logic [17:0] b_addr;

  logic [7:0]  sram [1024];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clkMem = ~clkMem;

  assign mem_rdata = sram[mem_addr[9:0]];
  assign b_rdata   = sram[b_addr[9:0]];

  // SRAM model: preloaded pattern, written only by the default-timing instance.
  initial begin
    for (int i = 0; i < 1024; i++) sram[i] = 8'(i * 37 + 11);
    sram[10'h123] = 8'hA5;
    forever begin
      @(posedge clkMem);
      if (!mem_ce_n && !mem_we_n && mem_wdata_oe) sram[mem_addr[9:0]] = mem_wdata;
    end
  end

  mem_arbiter #(.ADDR_W(18), .DATA_W(8), .ACCESS_CYCLES(AC), .VIDEO_MAX_BURST(VMB)) u_dut (
    .clkMem(clkMem), .rst_n(rst_n),
    .vid_req(vid_req), .cpu_req(cpu_req), .aux_req(aux_req),
    .vid_addr(vid_addr), .cpu_addr(cpu_addr), .aux_addr(aux_addr),
    .cpu_we(cpu_we), .aux_we(aux_we), .cpu_wdata(cpu_wdata), .aux_wdata(aux_wdata),
    .vid_ack(vid_ack), .cpu_ack(cpu_ack), .aux_ack(aux_ack), .rd_data(rd_data),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wdata_oe(mem_wdata_oe),
    .mem_rdata(mem_rdata), .mem_ce_n(mem_ce_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n),
    .busy(busy)
  );

  mem_arbiter #(.ADDR_W(18), .DATA_W(8), .ACCESS_CYCLES(ACB), .VIDEO_MAX_BURST(1)) u_fast (
    .clkMem(clkMem), .rst_n(rst_n),
    .vid_req(vid_req), .cpu_req(cpu_req), .aux_req(aux_req),
    .vid_addr(vid_addr), .cpu_addr(cpu_addr), .aux_addr(aux_addr),
    .cpu_we(cpu_we), .aux_we(aux_we), .cpu_wdata(cpu_wdata), .aux_wdata(aux_wdata),
    .vid_ack(b_vid_ack), .cpu_ack(b_cpu_ack), .aux_ack(b_aux_ack), .rd_data(b_rd_data),
    .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_wdata_oe(b_wdata_oe),
    .mem_rdata(b_rdata), .mem_ce_n(b_ce_n), .mem_oe_n(b_oe_n), .mem_we_n(b_we_n),
    .busy(b_busy)
  );

  task automatic do_reset();
    rst_n = 1'b0;
    {vid_req, cpu_req, aux_req, cpu_we, aux_we} = '0;
    {vid_addr, cpu_addr, aux_addr} = '0;
    {cpu_wdata, aux_wdata} = '0;
    repeat (2) @(posedge clkMem);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] got;
    rst_n = 1'b0;
    {vid_req, cpu_req, aux_req} = 3'b111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clkMem);
      got = {mem_ce_n, mem_oe_n, mem_we_n, mem_wdata_oe, busy, vid_ack, cpu_ack, aux_ack};
      n_vec++;
      if (got !== 8'b1110_0000) begin
        n_err++; $display("FAIL reset_ctrl cyc %0d got %b want 11100000", i, got);
      end
      n_vec++;
      if ({rd_data, mem_addr, mem_wdata} !== 34'd0) begin
        n_err++; $display("FAIL reset_data got rd=%h addr=%h wd=%h want 0", rd_data, mem_addr,
                          mem_wdata);
      end
      n_vec++;
      if ({b_ce_n, b_oe_n, b_we_n, b_busy} !== 4'b1110) begin
        n_err++; $display("FAIL reset_fast got %b want 1110", {b_ce_n, b_oe_n, b_we_n, b_busy});
      end
    end
    do_reset();
  endtask

  task automatic test_cpu_read();
    logic [7:0] got, exp;
    bit win, str, rec;
    do_reset();
    cpu_addr = 18'h00123; cpu_we = 1'b0; cpu_req = 1'b1;
    for (int i = 0; i <= AC + 3; i++) begin
      @(negedge clkMem);
      win = (i >= 1) && (i <= AC + 2);
      str = (i >= 2) && (i <= AC + 1);
      rec = (i == AC + 2);
      exp = {!win, !str, 1'b1, 1'b0, win, 1'b0, rec, 1'b0};
      got = {mem_ce_n, mem_oe_n, mem_we_n, mem_wdata_oe, busy, vid_ack, cpu_ack, aux_ack};
      n_vec++;
      if (got !== exp) begin
        n_err++; $display("FAIL rd_timeline cyc %0d got %b want %b", i, got, exp);
      end
      if (win) begin
        n_vec++;
        if (mem_addr !== 18'h00123) begin
          n_err++; $display("FAIL rd_addr cyc %0d got %h want 00123", i, mem_addr);
        end
      end
      if (rec) begin
        n_vec++;
        if (rd_data !== 8'hA5) begin
          n_err++; $display("FAIL rd_data got %h want a5", rd_data);
        end
      end
      @(posedge clkMem); #1;
      if (rec) cpu_req = 1'b0;
    end
  endtask

  task automatic test_cpu_write();
    logic [7:0] got, exp;
    bit win, str, rec;
    int k;
    cpu_addr = 18'h00010; cpu_wdata = 8'h3C; cpu_we = 1'b1; cpu_req = 1'b1;
    for (int i = 0; i <= AC + 3; i++) begin
      @(negedge clkMem);
      win = (i >= 1) && (i <= AC + 2);
      str = (i >= 2) && (i <= AC + 1);
      rec = (i == AC + 2);
      exp = {!win, 1'b1, !str, win, win, 1'b0, rec, 1'b0};
      got = {mem_ce_n, mem_oe_n, mem_we_n, mem_wdata_oe, busy, vid_ack, cpu_ack, aux_ack};
      n_vec++;
      if (got !== exp) begin
        n_err++; $display("FAIL wr_timeline cyc %0d got %b want %b", i, got, exp);
      end
      if (win) begin
        n_vec++;
        if ({mem_addr, mem_wdata} !== {18'h00010, 8'h3C}) begin
          n_err++; $display("FAIL wr_bus cyc %0d got %h/%h want 00010/3c", i, mem_addr, mem_wdata);
        end
      end
      if (rec) begin
        n_vec++;
        if (rd_data !== 8'hA5) begin
          n_err++; $display("FAIL wr_keeps_rd got %h want a5", rd_data);
        end
      end
      @(posedge clkMem); #1;
      if (rec) cpu_req = 1'b0;
    end
    cpu_we = 1'b0; cpu_req = 1'b1;
    k = 0;
    do begin @(negedge clkMem); k++; end while (!(vid_ack | cpu_ack | aux_ack) && k < 20);
    n_vec++;
    if (!cpu_ack || rd_data !== 8'h3C) begin
      n_err++; $display("FAIL readback got ack=%b rd=%h want ack=1 rd=3c", cpu_ack, rd_data);
    end
    @(posedge clkMem); #1 cpu_req = 1'b0;
  endtask

  task automatic test_all_video();
    logic [2:0] got, exp;
    int k;
    do_reset();
    vid_addr = 18'h00200; cpu_addr = 18'h00201; aux_addr = 18'h00202;
    {vid_req, cpu_req, aux_req} = 3'b111;
    for (int g = 0; g < 20; g++) begin
      k = 0;
      do begin @(negedge clkMem); k++; end while (!(vid_ack | cpu_ack | aux_ack) && k < 20);
      got = {vid_ack, cpu_ack, aux_ack};
      exp = (g % 10 == 4) ? 3'b010 : (g % 10 == 9) ? 3'b001 : 3'b100;
      n_vec++;
      if (got !== exp || k != AC + 3) begin
        n_err++; $display("FAIL all3_order grant %0d got %b after %0d want %b after %0d", g, got, k,
                          exp, AC + 3);
        break;
      end
    end
    @(posedge clkMem); #1 {vid_req, cpu_req, aux_req} = 3'b000;
  endtask

  task automatic test_cpu_aux_rr();
    logic [2:0] got, exp;
    int k;
    do_reset();
    {cpu_req, aux_req} = 2'b11;
    for (int g = 0; g < 8; g++) begin
      k = 0;
      do begin @(negedge clkMem); k++; end while (!(vid_ack | cpu_ack | aux_ack) && k < 20);
      got = {vid_ack, cpu_ack, aux_ack};
      exp = (g % 2 == 0) ? 3'b010 : 3'b001;
      n_vec++;
      if (got !== exp || k != AC + 3) begin
        n_err++; $display("FAIL rr_order grant %0d got %b after %0d want %b after %0d", g, got, k,
                          exp, AC + 3);
        break;
      end
    end
    @(posedge clkMem); #1 {cpu_req, aux_req} = 2'b00;
  endtask

  task automatic test_reset_mid_write();
    logic [2:0] got, exp;
    int k;
    do_reset();
    cpu_addr = 18'h00055; cpu_wdata = 8'h99; cpu_we = 1'b1; cpu_req = 1'b1;
    repeat (3) @(negedge clkMem);
    n_vec++;
    if ({mem_ce_n, mem_we_n} !== 2'b00) begin
      n_err++; $display("FAIL midwr_strobe got ce/we %b want 00", {mem_ce_n, mem_we_n});
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({mem_ce_n, mem_oe_n, mem_we_n, mem_wdata_oe, busy} !== 5'b11100) begin
      n_err++; $display("FAIL async_reset got %b want 11100",
                        {mem_ce_n, mem_oe_n, mem_we_n, mem_wdata_oe, busy});
    end
    cpu_req = 1'b0; cpu_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clkMem);
      n_vec++;
      if ({vid_ack, cpu_ack, aux_ack} !== 3'b000) begin
        n_err++; $display("FAIL reset_no_ack got %b want 000", {vid_ack, cpu_ack, aux_ack});
      end
    end
    @(posedge clkMem); #1 rst_n = 1'b1;
    {vid_req, cpu_req, aux_req} = 3'b111;
    for (int g = 0; g < 5; g++) begin
      k = 0;
      do begin @(negedge clkMem); k++; end while (!(vid_ack | cpu_ack | aux_ack) && k < 20);
      got = {vid_ack, cpu_ack, aux_ack};
      exp = (g == 4) ? 3'b010 : 3'b100;
      n_vec++;
      if (got !== exp) begin
        n_err++; $display("FAIL post_reset_order grant %0d got %b want %b", g, got, exp);
        break;
      end
    end
    @(posedge clkMem); #1 {vid_req, cpu_req, aux_req} = 3'b000;
  endtask

  task automatic test_fast();
    logic [2:0] got, exp;
    int k;
    do_reset();
    {vid_req, cpu_req} = 2'b11;
    for (int g = 0; g < 8; g++) begin
      k = 0;
      do begin @(negedge clkMem); k++; end while (!(b_vid_ack | b_cpu_ack | b_aux_ack) && k < 20);
      got = {b_vid_ack, b_cpu_ack, b_aux_ack};
      exp = (g % 2 == 0) ? 3'b100 : 3'b010;
      n_vec++;
      if (got !== exp || k != ACB + 3) begin
        n_err++; $display("FAIL fast_order grant %0d got %b after %0d want %b after %0d", g, got, k,
                          exp, ACB + 3);
        break;
      end
    end
    @(posedge clkMem); #1 {vid_req, cpu_req} = 2'b00;
  endtask

  task automatic test_random();
    bit          pend [3];
    logic [17:0] pa [3];
    logic        pw [3];
    logic [7:0]  pd [3];
    logic [7:0]  ref_mem [1024];
    logic [7:0]  last_rd;
    logic [2:0]  got, exp;
    int          burst, w, k;
    bit          rr_aux;
    do_reset();
    for (int i = 0; i < 1024; i++) ref_mem[i] = sram[i];
    for (int p = 0; p < 3; p++) begin
      pend[p] = 1'b0; pa[p] = '0; pw[p] = 1'b0; pd[p] = '0;
    end
    last_rd = 8'h00; burst = 0; rr_aux = 1'b0;
    for (int r = 0; r < 250; r++) begin
      for (int p = 0; p < 3; p++) begin
        if (!pend[p] && $urandom_range(1, 0) == 1) begin
          pend[p] = 1'b1;
          pa[p]   = 18'($urandom);
          pw[p]   = (p != 0) && ($urandom_range(2, 0) == 0);
          pd[p]   = 8'($urandom);
        end
      end
      vid_req = pend[0]; vid_addr = pa[0];
      cpu_req = pend[1]; cpu_addr = pa[1]; cpu_we = pw[1]; cpu_wdata = pd[1];
      aux_req = pend[2]; aux_addr = pa[2]; aux_we = pw[2]; aux_wdata = pd[2];
      if (!(pend[0] || pend[1] || pend[2])) begin
        @(posedge clkMem); #1;
        burst = 0;
        continue;
      end
      if (pend[0] && (burst < VMB || !(pend[1] || pend[2]))) w = 0;
      else if (pend[1] && pend[2]) w = rr_aux ? 2 : 1;
      else w = pend[1] ? 1 : 2;
      exp = 3'(3'b100 >> w);
      k = 0;
      do begin @(negedge clkMem); k++; end while (!(vid_ack | cpu_ack | aux_ack) && k < 20);
      got = {vid_ack, cpu_ack, aux_ack};
      n_vec++;
      if (got !== exp || k != AC + 3) begin
        n_err++; $display("FAIL rand_grant round %0d got %b after %0d want %b after %0d", r, got, k,
                          exp, AC + 3);
        break;
      end
      if (pw[w]) ref_mem[pa[w][9:0]] = pd[w];
      else last_rd = ref_mem[pa[w][9:0]];
      n_vec++;
      if (mem_addr !== pa[w] || rd_data !== last_rd) begin
        n_err++; $display("FAIL rand_data round %0d got addr=%h rd=%h want addr=%h rd=%h", r,
                          mem_addr, rd_data, pa[w], last_rd);
      end
      burst  = (w == 0) ? ((burst < 15) ? burst + 1 : 15) : 0;
      if (w == 1) rr_aux = 1'b1;
      if (w == 2) rr_aux = 1'b0;
      pend[w] = 1'b0;
      @(posedge clkMem); #1;
    end
    {vid_req, cpu_req, aux_req} = 3'b000;
    repeat (2) @(posedge clkMem);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t want finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    #1;
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_all_video();
    test_cpu_aux_rr();
    test_reset_mid_write();
    test_fast();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
